// File: rtl/cmd_alu_pkg.sv
// rtl/cmd_alu_pkg.sv - shared types and helpers for the command ALU
package cmd_alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        RSP      = 2'd2
    } state_e;

    localparam int MUL_CNT_W = 4;

    function automatic logic is_legal_op(input op_e op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/cmd_alu_mul.sv
// rtl/cmd_alu_mul.sv - latched-operand multiplier with a load/done countdown
module cmd_alu_mul
    import cmd_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [MUL_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= MUL_CNT_W'(MUL_LAT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Done fires on the last busy cycle so the top can register the product
    // and raise rsp_valid exactly MUL_LAT cycles after accept.
    assign o_done    = (r_cnt == MUL_CNT_W'(1));
    assign o_product = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

endmodule

// File: rtl/cmd_alu.sv
// rtl/cmd_alu.sv - command-driven ALU with tagged valid/ready responses
module cmd_alu
    import cmd_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err
);

    if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("cmd_alu: MUL_LAT must be in 2..15");
    end

    state_e             r_state;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_err;

    op_e                w_op;
    logic               w_accept;
    logic               w_mul_load;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_alu_result;

    assign w_op       = op_e'(cmd_op);
    assign cmd_ready  = (r_state == IDLE);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_mul_load = w_accept & (w_op == OP_MUL);
    assign w_sum      = {1'b0, cmd_a} + {1'b0, cmd_b};

    always_comb begin
        w_alu_result = '0;
        case (w_op)
            OP_ADD:  w_alu_result = {{(WIDTH-1){1'b0}}, w_sum};
            OP_AND:  w_alu_result = {{WIDTH{1'b0}}, cmd_a & cmd_b};
            OP_XOR:  w_alu_result = {{WIDTH{1'b0}}, cmd_a ^ cmd_b};
            default: w_alu_result = '0;
        endcase
    end

    cmd_alu_mul #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_mul_load),
        .i_a       (cmd_a),
        .i_b       (cmd_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_op == OP_MUL) begin
                            r_rsp_tag <= cmd_tag;
                            r_rsp_err <= 1'b0;
                            r_state   <= MUL_BUSY;
                        end else if (w_op != OP_NOP) begin
                            r_rsp_result <= w_alu_result;
                            r_rsp_tag    <= cmd_tag;
                            r_rsp_err    <= ~is_legal_op(w_op);
                            r_state      <= RSP;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (w_mul_done) begin
                        r_rsp_result <= w_mul_product;
                        r_state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = (r_state == RSP);
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;

    a_op_known: assert property (@(posedge clk) disable iff (!reset_n)
        cmd_valid |-> !$isunknown(cmd_op));

endmodule

// File: tb/tb_cmd_alu.sv
// tb/tb_cmd_alu.sv - table-driven self-checking bench for cmd_alu
module tb_cmd_alu;
    import cmd_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic [3:0]  cmd_tag = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_alu #(.WIDTH(8), .TAG_W(4), .MUL_LAT(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge with cmd_* scrambled.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = ~a;
        cmd_b     = ~b;
        cmd_tag   = ~tag;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        vecs[0] = '{3'd1, 8'hFF, 8'h01, 4'd3,  16'h0100, 1'b0, 1};
        vecs[1] = '{3'd1, 8'h7F, 8'h01, 4'd1,  16'h0080, 1'b0, 1};
        vecs[2] = '{3'd1, 8'hFF, 8'hFF, 4'd14, 16'h01FE, 1'b0, 1};
        vecs[3] = '{3'd2, 8'hF0, 8'h3C, 4'd5,  16'h0030, 1'b0, 1};
        vecs[4] = '{3'd3, 8'hA5, 8'h0F, 4'd6,  16'h00AA, 1'b0, 1};
        vecs[5] = '{3'd4, 8'hFF, 8'hFF, 4'd9,  16'hFE01, 1'b0, 3};
        vecs[6] = '{3'd4, 8'hC3, 8'h02, 4'd10, 16'h0186, 1'b0, 3};
        vecs[7] = '{3'd4, 8'h00, 8'hAB, 4'd11, 16'h0000, 1'b0, 3};
        vecs[8] = '{3'd7, 8'h12, 8'h34, 4'd12, 16'h0000, 1'b1, 1};
        vecs[9] = '{3'd5, 8'h55, 8'h0F, 4'd13, 16'h0000, 1'b1, 1};

        #2 reset_n = 1'b0;
        #1;
        check("reset_rsp_valid",  32'(rsp_valid),  32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_tag",    32'(rsp_tag),    32'd0);
        check("reset_rsp_err",    32'(rsp_err),    32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_rsp(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rsp_cmd_ready", i), 32'(cmd_ready), 32'd0);
            check($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].exp_res));
            check($sformatf("v%0d_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
            check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_after_xfer_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d_after_xfer_ready", i), 32'(cmd_ready), 32'd1);
        end

        // Response held under backpressure
        rsp_ready = 1'b0;
        send(3'd3, 8'hA5, 8'h0F, 4'd2);
        held = 16'h00AA;
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid",  32'(rsp_valid),  32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'(held));
            check("bp_rsp_tag",    32'(rsp_tag),    32'd2);
            check("bp_cmd_ready",  32'(cmd_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(cmd_ready), 32'd1);

        // NOP produces no response
        send(3'd0, 8'h11, 8'h22, 4'd7);
        for (int c = 0; c < 4; c++) begin
            check("nop_rsp_valid", 32'(rsp_valid), 32'd0);
            check("nop_cmd_ready", 32'(cmd_ready), 32'd1);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a multiply discards it
        send(3'd4, 8'h0F, 8'h0F, 4'd8);
        @(posedge clk);
        #1;
        check("mul_mid_busy", 32'(cmd_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_reset_rsp_valid",  32'(rsp_valid),  32'd0);
        check("mid_reset_rsp_result", 32'(rsp_result), 32'd0);
        check("mid_reset_rsp_tag",    32'(rsp_tag),    32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        send(3'd1, 8'h01, 8'h01, 4'd4);
        wait_rsp(lat);
        check("post_reset_add_lat",    32'(lat),        32'd1);
        check("post_reset_add_result", 32'(rsp_result), 32'h0002);
        check("post_reset_add_tag",    32'(rsp_tag),    32'd4);
        @(posedge clk);
        #1;
        check("post_reset_add_idle", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
